// File: rtl/arythmecrypt_pkg.sv
// Shared types, constants and round primitives for the arythmecrypt
// encryptor/decryptor pair.
package arythmecrypt_pkg;

  typedef enum logic [1:0] {
    S_NOKEY = 2'd0,
    S_IDLE  = 2'd1,
    S_ROUND = 2'd2,
    S_OUT   = 2'd3
  } state_t;

  // Feedback taps of the key-advance LFSR: bits 7, 5, 4, 3.
  localparam logic [7:0]  LFSR_TAPS        = 8'hB8;
  localparam logic [7:0]  KEY_STEP_DEFAULT = 8'h35;
  localparam int unsigned ROT_AMT          = 3;

  function automatic logic [7:0] rotl(input logic [7:0] v);
    return (v << ROT_AMT) | (v >> (8 - ROT_AMT));
  endfunction

  function automatic logic [7:0] rotr(input logic [7:0] v);
    return (v >> ROT_AMT) | (v << (8 - ROT_AMT));
  endfunction

  function automatic logic [7:0] round_fwd(input logic [7:0] x, input logic [7:0] k);
    return rotl(x ^ k) + k;
  endfunction

  function automatic logic [7:0] round_inv(input logic [7:0] x, input logic [7:0] k);
    return rotr(x - k) ^ k;
  endfunction

  function automatic logic [7:0] lfsr_step(input logic [7:0] ks);
    return {ks[6:0], ^(ks & LFSR_TAPS)};
  endfunction

  // A zero key would lock the LFSR, so it is replaced by 1.
  function automatic logic [7:0] key_seed(input logic [7:0] k);
    return (k == 8'h00) ? 8'h01 : k;
  endfunction

endpackage

// File: rtl/arythmecrypt_round_inv.sv
// One combinational inverse round: x' = rotr3(x - k) ^ k.
module arythmecrypt_round_inv
  import arythmecrypt_pkg::*;
(
  input  logic [7:0] x_i,
  input  logic [7:0] k_i,
  output logic [7:0] x_o
);

  assign x_o = round_inv(x_i, k_i);

endmodule

// File: rtl/arythmecrypt_decrypt.sv
// Byte-serial decryptor: accepts one ciphertext byte, runs ROUNDS inverse
// rounds (one per cycle) and holds the plaintext until consumed.
module arythmecrypt_decrypt
  import arythmecrypt_pkg::*;
#(
  parameter int         ROUNDS   = 2,
  parameter logic [7:0] KEY_STEP = KEY_STEP_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_load,
  input  logic [7:0] key_in,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  output logic       in_ready,
  output logic       out_valid,
  output logic [7:0] out_data,
  input  logic       out_ready,
  output logic       busy,
  output logic [7:0] byte_count
);

  localparam logic [2:0] R_LAST = 3'(ROUNDS - 1);

  state_t     state_q, state_d;
  logic [7:0] ks_q, ks_d;
  logic [7:0] x_q, x_d;
  logic [2:0] r_q, r_d;
  logic [7:0] cnt_q, cnt_d;
  logic       in_ready_q, out_valid_q, busy_q;
  logic [7:0] round_key_s, round_out_s;

  // Rounds are consumed from r = ROUNDS-1 down to 0, undoing the encryptor.
  assign round_key_s = ks_q + (KEY_STEP * {5'd0, r_q});

  arythmecrypt_round_inv u_round_inv (
    .x_i (x_q),
    .k_i (round_key_s),
    .x_o (round_out_s)
  );

  // Next-state logic; key_load preempts every handshake.
  always_comb begin
    state_d = state_q;
    ks_d    = ks_q;
    x_d     = x_q;
    r_d     = r_q;
    cnt_d   = cnt_q;
    if (key_load) begin
      ks_d    = key_seed(key_in);
      cnt_d   = 8'd0;
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_NOKEY: state_d = S_NOKEY;
        S_IDLE: begin
          if (in_valid) begin
            x_d     = in_data;
            r_d     = R_LAST;
            state_d = S_ROUND;
          end else begin
            state_d = S_IDLE;
          end
        end
        S_ROUND: begin
          x_d = round_out_s;
          if (r_q == 3'd0) begin
            state_d = S_OUT;
          end else begin
            r_d = r_q - 3'd1;
          end
        end
        S_OUT: begin
          if (out_ready) begin
            ks_d    = lfsr_step(ks_q);
            cnt_d   = cnt_q + 8'd1;
            state_d = S_IDLE;
          end else begin
            state_d = S_OUT;
          end
        end
        default: state_d = S_NOKEY;
      endcase
    end
  end

  // State, datapath and output registers; outputs decode the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_NOKEY;
      ks_q        <= 8'd0;
      x_q         <= 8'd0;
      r_q         <= 3'd0;
      cnt_q       <= 8'd0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      ks_q        <= ks_d;
      x_q         <= x_d;
      r_q         <= r_d;
      cnt_q       <= cnt_d;
      in_ready_q  <= (state_d == S_IDLE);
      out_valid_q <= (state_d == S_OUT);
      busy_q      <= (state_d == S_ROUND) || (state_d == S_OUT);
    end
  end

  assign in_ready   = in_ready_q;
  assign out_valid  = out_valid_q;
  assign out_data   = x_q;
  assign busy       = busy_q;
  assign byte_count = cnt_q;

endmodule
